complete_arbiter: RTL

Arbitrates completed results from four execution sources (ALU0, ALU1, ALU2, LSU) onto the three completion lanes that feed the `complete` stage. It sits between the functional units and the `complete` stage.
- Each source gets a small FIFO, so no result is lost when more than three finish in one cycle.
- Up to three heads are granted per cycle, in round-robin order.
- Granted entries drive registered lanes: lanes 0-2 carry PC, destination register, data and ROB number.

---
 rtl/ooo_pkg.sv | 15 +
 rtl/cmpl_src_fifo.sv | 45 ++++
 rtl/complete_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/ooo_pkg.sv
// Types and constants shared by the completion arbiter and the complete stage.
package ooo_pkg;

    localparam int XLEN      = 32;
    localparam int TAG_W     = 6;
    localparam int NUM_LANES = 3;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [TAG_W-1:0] dest_reg;
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] rob;
    } cmpl_entry_t;

endpackage

// File: rtl/cmpl_src_fifo.sv
// Per-source result FIFO: power-of-two depth, registered count, head always visible.
module cmpl_src_fifo
    import ooo_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  cmpl_entry_t      i_din,
    output cmpl_entry_t      o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmpl_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_rst && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/complete_arbiter.sv
// Buffers results from the execution sources and grants up to NUM_LANES heads per
// cycle in round-robin order onto registered completion lanes.
module complete_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int NUM_LANES = ooo_pkg::NUM_LANES,
    parameter int DEPTH     = 2,
    parameter int XLEN      = ooo_pkg::XLEN,
    parameter int TAG_W     = ooo_pkg::TAG_W
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       stall,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*XLEN-1:0]    src_pc,
    input  logic [NUM_SRC*TAG_W-1:0]   src_dest_reg,
    input  logic [NUM_SRC*XLEN-1:0]    src_data,
    input  logic [NUM_SRC*TAG_W-1:0]   src_rob,
    output logic [NUM_LANES-1:0]       lane_valid,
    output logic [NUM_LANES*XLEN-1:0]  lane_pc,
    output logic [NUM_LANES*TAG_W-1:0] lane_dest_reg,
    output logic [NUM_LANES*XLEN-1:0]  lane_data,
    output logic [NUM_LANES*TAG_W-1:0] lane_rob
);

    import ooo_pkg::*;

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(DEPTH + 1);

    cmpl_entry_t          w_din   [NUM_SRC];
    cmpl_entry_t          w_head  [NUM_SRC];
    logic [CNT_W-1:0]     w_count [NUM_SRC];
    logic [NUM_SRC-1:0]   w_push;
    logic [NUM_SRC-1:0]   w_pop;

    logic [SRC_W-1:0]     w_lane_sel [NUM_LANES];
    logic [NUM_LANES-1:0] w_lane_hit;
    logic [SRC_W-1:0]     w_next_ptr;

    logic [SRC_W-1:0]     r_rr_ptr;
    logic [NUM_LANES-1:0] r_lane_valid;
    cmpl_entry_t          r_lane [NUM_LANES];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign w_din[g] = '{pc:       src_pc[g*XLEN +: XLEN],
                            dest_reg: src_dest_reg[g*TAG_W +: TAG_W],
                            data:     src_data[g*XLEN +: XLEN],
                            rob:      src_rob[g*TAG_W +: TAG_W]};
        // Readiness looks only at the current count, never at a same-cycle pop.
        assign src_ready[g] = (w_count[g] < CNT_W'(DEPTH)) && !rstn && !flush;
        assign w_push[g]    = src_valid[g] && src_ready[g];

        cmpl_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .i_clk   (clk),
            .i_rst   (rstn),
            .i_flush (flush),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_din   (w_din[g]),
            .o_head  (w_head[g]),
            .o_count (w_count[g])
        );
    end

    always_comb begin
        int n;
        int idx;
        n          = 0;
        idx        = 0;
        w_pop      = '0;
        w_lane_hit = '0;
        w_next_ptr = r_rr_ptr;
        for (int k = 0; k < NUM_LANES; k++) w_lane_sel[k] = '0;
        if (!stall) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                idx = (int'(r_rr_ptr) + j) % NUM_SRC;
                if (w_count[idx] != '0 && n < NUM_LANES) begin
                    w_pop[idx]    = 1'b1;
                    w_lane_hit[n] = 1'b1;
                    w_lane_sel[n] = SRC_W'(idx);
                    w_next_ptr    = SRC_W'((idx + 1) % NUM_SRC);
                    n             = n + 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn || flush) begin
            r_rr_ptr     <= '0;
            r_lane_valid <= '0;
            for (int k = 0; k < NUM_LANES; k++) r_lane[k] <= '0;
        end else if (!stall) begin
            r_rr_ptr     <= w_next_ptr;
            r_lane_valid <= w_lane_hit;
            for (int k = 0; k < NUM_LANES; k++)
                r_lane[k] <= w_lane_hit[k] ? w_head[w_lane_sel[k]] : '0;
        end
    end

    assign lane_valid = r_lane_valid;
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_pc[k*XLEN +: XLEN]         = r_lane[k].pc;
        assign lane_dest_reg[k*TAG_W +: TAG_W] = r_lane[k].dest_reg;
        assign lane_data[k*XLEN +: XLEN]       = r_lane[k].data;
        assign lane_rob[k*TAG_W +: TAG_W]      = r_lane[k].rob;
    end

endmodule
